// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with branch/jump/jr resolution, delay-slot semantics and redirect counting
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [2:0]  jmp_op,
  output logic [31:0] pc_f,
  output logic        fetch_en,
  output logic [31:0] link_d,
  output logic        taken,
  output logic        addr_err,
  output logic [31:0] br_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;
  state_t r_state, w_state_nxt;
  logic [31:0] r_pc, r_br_cnt, w_pc_d4, w_bt, w_jt, w_pc_nxt;
  logic r_addr_err, w_adv, w_beq, w_bne, w_j, w_jr, w_br_taken, w_mis;
  assign w_beq = jmp_op == 3'd1;
  assign w_bne = jmp_op == 3'd2;
  assign w_j = jmp_op == 3'd3;
  assign w_jr = jmp_op == 3'd4;
  assign w_pc_d4 = pc_d + 32'd4;
  assign w_bt = w_pc_d4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign w_jt = {w_pc_d4[31:28], instr_d[25:0], 2'b00};
  assign w_br_taken = (w_beq & (rs_val == rt_val)) | (w_bne & (rs_val != rt_val));
  assign taken = w_br_taken | w_j | w_jr;
  // misalignment only matters when the jr target would actually be applied
  assign w_mis = w_jr & (rs_val[1:0] != 2'b00);
  assign w_adv = (r_state == RUN) & ~stall & imem_ready;
  assign w_pc_nxt = w_br_taken ? w_bt : w_j ? w_jt : w_jr ? rs_val : r_pc + 32'd4;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == BOOT) w_state_nxt = RUN;
    else if (r_state == RUN && w_adv && w_mis) w_state_nxt = ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc <= RESET_PC;
      r_br_cnt <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        if (w_mis) r_addr_err <= 1'b1;
        else begin
          r_pc <= w_pc_nxt;
          if (taken) r_br_cnt <= r_br_cnt + 32'd1;
        end
      end
    end
  end
  assign pc_f = r_pc;
  assign fetch_en = (r_state == RUN) & ~stall;
  assign link_d = pc_d + 32'd8;
  assign addr_err = r_addr_err;
  assign br_cnt = r_br_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed expectations
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, imem_ready;
  logic [31:0] instr_d, pc_d, rs_val, rt_val;
  logic [2:0]  jmp_op;
  logic [31:0] pc_f, link_d, br_cnt;
  logic        fetch_en, taken, addr_err;
  int n_chk = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .instr_d(instr_d), .pc_d(pc_d), .rs_val(rs_val), .rt_val(rt_val),
    .jmp_op(jmp_op), .pc_f(pc_f), .fetch_en(fetch_en), .link_d(link_d),
    .taken(taken), .addr_err(addr_err), .br_cnt(br_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] pcd, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt);
    jmp_op = op; pc_d = pcd; instr_d = ins; rs_val = rs; rt_val = rt;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("boot_pc", pc_f, 32'h3000);
    chk("boot_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("boot_cnt", br_cnt, 32'd0);
    chk("boot_err", {31'd0, addr_err}, 32'd0);
    step();
    chk("run_pc", pc_f, 32'h3000);
    chk("run_fetch_en", {31'd0, fetch_en}, 32'd1);
    step();
    chk("seq1_pc", pc_f, 32'h3004);
    step();
    chk("seq2_pc", pc_f, 32'h3008);
    drive(3'd1, 32'h3004, 32'h0000_0003, 32'd5, 32'd5);
    #1 chk("beq_taken", {31'd0, taken}, 32'd1);
    step();
    chk("beq_pc", pc_f, 32'h3014);
    chk("beq_cnt", br_cnt, 32'd1);
    rt_val = 32'd6;
    #1 chk("beq_nt_taken", {31'd0, taken}, 32'd0);
    step();
    chk("beq_nt_pc", pc_f, 32'h3018);
    chk("beq_nt_cnt", br_cnt, 32'd1);
    drive(3'd1, 32'h3004, 32'h0000_FFFF, 32'd7, 32'd7);
    step();
    chk("beq_neg_pc", pc_f, 32'h3004);
    chk("beq_neg_cnt", br_cnt, 32'd2);
    drive(3'd2, 32'h3004, 32'h0000_0003, 32'd1, 32'd1);
    #1 chk("bne_nt_taken", {31'd0, taken}, 32'd0);
    step();
    chk("bne_nt_pc", pc_f, 32'h3008);
    drive(3'd3, 32'h3008, 32'h0000_0C05, 32'd0, 32'd0);
    #1 chk("j_link", link_d, 32'h3010);
    step();
    chk("j_pc", pc_f, 32'h3014);
    chk("j_cnt", br_cnt, 32'd3);
    drive(3'd4, 32'h3010, 32'h0, 32'h3100, 32'd0);
    step();
    chk("jr_pc", pc_f, 32'h3100);
    chk("jr_cnt", br_cnt, 32'd4);
    drive(3'd1, 32'h3100, 32'h0000_0010, 32'd9, 32'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_pc", i), pc_f, 32'h3100);
      chk($sformatf("stall%0d_cnt", i), br_cnt, 32'd4);
      chk($sformatf("stall%0d_fetch_en", i), {31'd0, fetch_en}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("stall_rel_pc", pc_f, 32'h3144);
    chk("stall_rel_cnt", br_cnt, 32'd5);
    drive(3'd0, 32'h3100, 32'h0, 32'd0, 32'd0);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("bp%0d_pc", i), pc_f, 32'h3144);
      chk($sformatf("bp%0d_fetch_en", i), {31'd0, fetch_en}, 32'd1);
    end
    imem_ready = 1'b1;
    step();
    chk("bp_rel_pc", pc_f, 32'h3148);
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_br_cnt;
    drive(3'd3, 32'h3008, 32'h0000_0C05, 32'd0, 32'd0);
    step();
    chk("wrap_pc", pc_f, 32'h3014);
    chk("wrap_cnt", br_cnt, 32'd0);
    drive(3'd4, 32'h3010, 32'h0, 32'h3102, 32'd0);
    step();
    chk("mis_err", {31'd0, addr_err}, 32'd1);
    chk("mis_pc", pc_f, 32'h3014);
    chk("mis_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("mis_cnt", br_cnt, 32'd0);
    drive(3'd4, 32'h3010, 32'h0, 32'h3200, 32'd0);
    step();
    step();
    chk("err_hold_pc", pc_f, 32'h3014);
    chk("err_hold_err", {31'd0, addr_err}, 32'd1);
    chk("err_hold_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("err_hold_cnt", br_cnt, 32'd0);
    chk("err_taken_comb", {31'd0, taken}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("rst_cnt", br_cnt, 32'd0);
    drive(3'd1, 32'h3004, 32'h0000_0003, 32'd5, 32'd5);
    step();
    chk("rst_boot_pc", pc_f, 32'h3000);
    step();
    chk("post_rst_pc", pc_f, 32'h3014);
    chk("post_rst_cnt", br_cnt, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_pc", pc_f, 32'h3000);
    chk("midrst_cnt", br_cnt, 32'd0);
    chk("midrst_fetch_en", {31'd0, fetch_en}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
